// File: rtl/cas_player.sv
// rtl/cas_player.sv - cassette playback: byte FIFO feeding an LSB-first CoCo FSK serialiser
module cas_player #(
    parameter int HALF0   = 20833,
    parameter int HALF1   = 10417,
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         din,
    input  logic               din_valid,
    output logic               din_ready,
    input  logic               motor,
    output logic               cas_out,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               underrun
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int HMAX  = (HALF0 > HALF1) ? HALF0 : HALF1;
    localparam int CW    = $clog2(HMAX + 1);
    localparam logic [CW-1:0]    H0    = CW'(HALF0);
    localparam logic [CW-1:0]    H1    = CW'(HALF1);
    localparam logic [FIFO_AW:0] FULLC = (FIFO_AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               wr_en, pop, fifo_empty;
    logic [7:0]         head;

    state_t        state, state_n;
    logic [7:0]    shreg, shreg_n;
    logic [2:0]    idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          underrun_n;

    assign din_ready  = (count != FULLC);
    assign wr_en      = din_valid & din_ready;
    assign fifo_empty = (count == '0);
    assign head       = mem[rd_ptr];
    assign fifo_level = count;
    assign cas_out    = (state == HIGH);
    assign busy       = (state != IDLE);

    function automatic logic [CW-1:0] half_len(input logic b);
        return b ? H1 : H0;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shreg    <= '0;
            idx      <= '0;
            cnt      <= '0;
            underrun <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            idx      <= idx_n;
            cnt      <= cnt_n;
            underrun <= underrun_n;
        end
    end

    // Every transition needs motor high, so a pause freezes state and counter.
    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        idx_n      = idx;
        cnt_n      = cnt;
        pop        = 1'b0;
        underrun_n = 1'b0;
        case (state)
            IDLE: begin
                if (motor && !fifo_empty) begin
                    pop     = 1'b1;
                    shreg_n = head;
                    idx_n   = 3'd0;
                    cnt_n   = half_len(head[0]);
                    state_n = HIGH;
                end
            end
            HIGH: begin
                if (motor) begin
                    if (cnt == CW'(1)) begin
                        cnt_n   = half_len(shreg[0]);
                        state_n = LOW;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
            end
            LOW: begin
                if (motor) begin
                    if (cnt != CW'(1)) begin
                        cnt_n = cnt - 1'b1;
                    end else if (idx != 3'd7) begin
                        shreg_n = {1'b0, shreg[7:1]};
                        idx_n   = idx + 3'd1;
                        cnt_n   = half_len(shreg[1]);
                        state_n = HIGH;
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_n = head;
                        idx_n   = 3'd0;
                        cnt_n   = half_len(head[0]);
                        state_n = HIGH;
                    end else begin
                        underrun_n = 1'b1;
                        state_n    = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cas_player.sv
// tb/tb_cas_player.sv - self-checking bench for cas_player against a waveform-level playback model
module tb_cas_player;
    localparam int HALF0 = 8;
    localparam int HALF1 = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    din = '0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic          motor = 1'b0;
    logic          cas_out;
    logic          busy;
    logic [AW:0]   fifo_level;
    logic          underrun;

    int checks = 0;
    int errors = 0;

    cas_player #(.HALF0(HALF0), .HALF1(HALF1), .FIFO_AW(AW)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .motor(motor), .cas_out(cas_out), .busy(busy), .fifo_level(fifo_level), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        motor = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        din = b;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    // Model: each bit is h cycles high then h cycles low (h from the bit value), bytes LSB first,
    // counted in motor-on edges; motor-off edges hold the previous output.
    task automatic play_stream(input logic [7:0] bytes[$], input int pause_at, input int pause_len,
                               input string name);
        bit  wave[$];
        int  t, k, offcnt, mism, first_bad, n_und, total;
        logic m_used;
        logic [2:0] exp_v, act_v, bad_exp, bad_act;
        foreach (bytes[j]) begin
            for (int i = 0; i < 8; i++) begin
                int h;
                h = bytes[j][i] ? HALF1 : HALF0;
                repeat (h) wave.push_back(1'b1);
                repeat (h) wave.push_back(1'b0);
            end
        end
        motor = 1'b0;
        foreach (bytes[j]) write_byte(bytes[j]);
        checks++;
        if (fifo_level !== (AW+1)'(bytes.size())) begin
            errors++;
            $display("FAIL %s load_level: got %0d want %0d", name, fifo_level, bytes.size());
        end
        t = wave.size();
        k = 0; offcnt = 0; mism = 0; first_bad = -1; n_und = 0;
        bad_exp = '0; bad_act = '0;
        total = t + pause_len + 6;
        motor = !(k == pause_at && offcnt < pause_len);
        for (int c = 0; c < total; c++) begin
            m_used = motor;
            @(negedge clk);
            if (m_used) k++; else offcnt++;
            if (k == 0)      exp_v = 3'b000;
            else if (k <= t) exp_v = {wave[k-1], 1'b1, 1'b0};
            else             exp_v = {1'b0, 1'b0, (m_used && k == t + 1)};
            act_v = {cas_out, busy, underrun};
            if (underrun === 1'b1) n_und++;
            if (act_v !== exp_v) begin
                mism++;
                if (first_bad < 0) begin
                    first_bad = c;
                    bad_exp = exp_v;
                    bad_act = act_v;
                end
            end
            motor = !(k == pause_at && offcnt < pause_len);
        end
        motor = 1'b0;
        checks++;
        if (mism !== 0) begin
            errors++;
            $display("FAIL %s waveform: %0d bad cycles, first at %0d {cas,busy,underrun} got %b want %b",
                     name, mism, first_bad, bad_act, bad_exp);
        end
        checks++;
        if (n_und !== 1) begin
            errors++;
            $display("FAIL %s underrun_count: got %0d want 1", name, n_und);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        checks++;
        if ({cas_out, busy, underrun, din_ready} !== 4'b0001 || fifo_level !== '0) begin
            errors++;
            $display("FAIL reset_state: cas=%b busy=%b und=%b rdy=%b lvl=%0d want 0 0 0 1 0",
                     cas_out, busy, underrun, din_ready, fifo_level);
        end
        do_reset();
    endtask

    task automatic test_start_latency();
        motor = 1'b1;
        write_byte(8'h80);
        checks++;
        if (fifo_level !== 5'd1 || cas_out !== 1'b0) begin
            errors++;
            $display("FAIL start_edge_n: lvl=%0d cas=%b want 1 0", fifo_level, cas_out);
        end
        @(negedge clk);
        checks++;
        if (fifo_level !== 5'd0 || cas_out !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_edge_n1: lvl=%0d cas=%b busy=%b want 0 1 1", fifo_level, cas_out, busy);
        end
        do_reset();
    endtask

    task automatic test_single_byte();
        logic [7:0] q[$];
        q = {8'h01};
        play_stream(q, -1, 0, "single_01");
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        q = {8'hFF, 8'h00};
        play_stream(q, -1, 0, "b2b_ff_00");
    endtask

    task automatic test_motor_pause();
        logic [7:0] q[$];
        q = {8'h55};
        play_stream(q, 36, 50, "pause_55");
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            logic [7:0] q[$];
            int n;
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            play_stream(q, $urandom_range(1, 60), $urandom_range(0, 20), $sformatf("random%0d", r));
        end
    endtask

    task automatic test_full_fifo_and_midstream_reset();
        int accepted;
        logic rdy;
        motor = 1'b0;
        accepted = 0;
        @(negedge clk);
        din_valid = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            din = 8'(8'h10 + i);
            rdy = din_ready;
            @(negedge clk);
            if (rdy) accepted++;
        end
        din_valid = 1'b0;
        checks++;
        if (accepted !== DEPTH || fifo_level !== (AW+1)'(DEPTH) || din_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_fifo: accepted=%0d lvl=%0d rdy=%b want %0d %0d 0",
                     accepted, fifo_level, din_ready, DEPTH, DEPTH);
        end
        motor = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_level !== (AW+1)'(DEPTH - 1) || din_ready !== 1'b1 || cas_out !== 1'b1) begin
            errors++;
            $display("FAIL full_pop: lvl=%0d rdy=%b cas=%b want %0d 1 1",
                     fifo_level, din_ready, cas_out, DEPTH - 1);
        end
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({cas_out, busy, underrun, din_ready} !== 4'b0001 || fifo_level !== '0) begin
            errors++;
            $display("FAIL midstream_reset: cas=%b busy=%b und=%b rdy=%b lvl=%0d want 0 0 0 1 0",
                     cas_out, busy, underrun, din_ready, fifo_level);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (cas_out !== 1'b0 || busy !== 1'b0 || fifo_level !== '0) begin
            errors++;
            $display("FAIL after_reset_play: cas=%b busy=%b lvl=%0d want 0 0 0", cas_out, busy, fifo_level);
        end
        motor = 1'b0;
    endtask

    task automatic test_motor_off_idle();
        int activity;
        motor = 1'b0;
        write_byte(8'hA5);
        activity = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy !== 1'b0 || cas_out !== 1'b0 || underrun !== 1'b0 || fifo_level !== 5'd1)
                activity++;
        end
        checks++;
        if (activity !== 0) begin
            errors++;
            $display("FAIL motor_off_idle: %0d cycles with activity, lvl=%0d busy=%b cas=%b want 0 cycles",
                     activity, fifo_level, busy, cas_out);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_start_latency();
        test_single_byte();
        test_back_to_back();
        test_motor_pause();
        test_full_fifo_and_midstream_reset();
        test_motor_off_idle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cas_player.md
# cas_player

Cassette playback stage for the CoCo2 core. It buffers tape image bytes delivered by the loader path (ioctl) and serialises them LSB-first as CoCo FSK audio: one full 1200 Hz cycle for a 0 bit and one full 2400 Hz cycle for a 1 bit. Its 1-bit output drives the cassette-input bit of PIA1 port A (bit 0). Playback is gated by the cassette motor control from PIA1 CA2.

## Interface
Parameters:
- HALF0, 20833: clock cycles per half-period of a 0 bit (1200 Hz at 50 MHz).
- HALF1, 10417: clock cycles per half-period of a 1 bit (2400 Hz at 50 MHz).
- FIFO_AW, 4: FIFO address width; depth is 2^FIFO_AW bytes.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-low reset.
- din  in  8  tape byte from the loader.
- din_valid  in  1  din is valid this cycle.
- din_ready  out  1  FIFO can accept a byte; a transfer occurs when din_valid & din_ready at a clk edge.
- motor  in  1  cassette motor on (PIA1 CA2 out); 1 = play.
- cas_out  out  1  FSK audio bit to PIA1 port A bit 0.
- busy  out  1  high whenever the state is not IDLE.
- fifo_level  out  FIFO_AW+1  number of bytes currently buffered.
- underrun  out  1  one-cycle pulse when a byte finishes with the FIFO empty while motor = 1.

## Operation
- FIFO: synchronous, registered count. din_ready = (fifo_level != 2^FIFO_AW), decoded from registered state.
  - A write and a pop in the same cycle leave fifo_level unchanged.
  - A write when full is impossible, because ready is low.
- Serialiser holds:
  - an 8-bit shift register, LSB transmitted first;
  - a 3-bit bit index;
  - a half-period counter sized for max(HALF0, HALF1).
- States:
  - IDLE: cas_out = 0. If motor & FIFO non-empty: pop the head byte into the shift register, set bit index = 0, load the counter from the LSB (HALF1 if the LSB is 1, else HALF0), go to HIGH.
  - HIGH: cas_out = 1. Counter decrements each cycle while motor = 1. On reaching 1, reload the counter with the same half length and go to LOW.
  - LOW: cas_out = 0. Counter decrements each cycle while motor = 1. On reaching 1:
    - If bit index < 7: shift right, increment the index, load the counter for the new LSB, go to HIGH.
    - If bit index = 7 and motor & FIFO non-empty: pop the next byte with no gap and go to HIGH.
    - Otherwise: go to IDLE, and pulse underrun if motor = 1.
- Motor low in HIGH/LOW: the counter and state freeze and cas_out holds its level. Resuming continues exactly where playback stopped.
- Motor low in IDLE: no pops are made.
- Width rule: the counter is loaded with HALFx and the transition happens on the count-1 cycle, so each half lasts exactly HALFx motor-on cycles.

## Timing
- Reset (asynchronous, reset = 0):
  - State IDLE; FIFO emptied.
  - cas_out = 0, busy = 0, underrun = 0, fifo_level = 0, din_ready = 1.
  - A reset mid-byte discards the partial byte and all buffered bytes.
- Write latency: a byte accepted at edge N is visible in fifo_level after edge N.
- Start latency from IDLE with motor = 1:
  - The pop occurs at edge N+1.
  - cas_out = 1 and busy = 1 after edge N+1.
- Bit durations (motor held high):
  - A 1 bit lasts 2·HALF1 cycles.
  - A 0 bit lasts 2·HALF0 cycles.
  - A byte lasts the sum of its 8 bit durations; consecutive buffered bytes play back-to-back.
- underrun is asserted for the single cycle following the final LOW edge; busy falls on the same edge.

## Test plan
- Reset check: assert reset mid-stream.
  - Outputs become cas_out = 0, busy = 0, fifo_level = 0, din_ready = 1 immediately (asynchronously), with no clock needed.
- Single byte (HALF0 = 8, HALF1 = 4, motor = 1): write 0x01.
  - cas_out is high 4 cycles, then low 4.
  - Then 7 repetitions of high 8 / low 8 (120 cycles total).
  - busy then falls and underrun pulses once.
- Back-to-back: write 0xFF then 0x00.
  - 8 cycles of 4/4, immediately followed by 8 cycles of 8/8, with no idle gap and no underrun between bytes.
- Full FIFO (FIFO_AW = 4, motor = 0): write 17 bytes with din_valid held.
  - 16 are accepted; din_ready = 0 and fifo_level = 16.
  - Raising motor pops one byte, and din_ready returns to 1 on the following cycle.
- Motor pause: drop motor for 50 cycles in the middle of the HIGH half of bit 3 of 0x55.
  - cas_out holds 1 throughout the pause.
  - After the pause, the remaining high count completes, and total motor-on cycles per bit still equal 2·HALFx.
- Motor off in IDLE: write 0xA5 with motor = 0.
  - fifo_level stays 1, busy stays 0, cas_out stays 0, and no underrun pulses.
